// File: rtl/tape_arb_pkg.sv
// Shared types and defaults for the tape/CPU main-RAM arbiter.
package tape_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_ISSUE = 2'd1,
    CPU_DONE  = 2'd2,
    TAPE_WR   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tape_entry_t;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_WAIT   = 8;

endpackage

// File: rtl/tape_ram_arbiter_if.sv
// CPU, loader and RAM bus signals of the tape/CPU RAM arbiter.
interface tape_ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_complete;
  logic        tape_ready;
  logic        tape_drained;
  logic        tape_overflow;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  tape_wr, tape_addr, tape_dout, tape_complete,
    input  ram_q,
    output cpu_dout, cpu_ack,
    output tape_ready, tape_drained, tape_overflow,
    output ram_addr, ram_we, ram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output tape_wr, tape_addr, tape_dout, tape_complete,
    output ram_q,
    input  cpu_dout, cpu_ack,
    input  tape_ready, tape_drained, tape_overflow,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/tape_wr_fifo.sv
// Synchronous FIFO of loader writes; a push while full is dropped even if a pop
// happens on the same edge.
module tape_wr_fifo
  import tape_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  tape_entry_t din,
  output tape_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  tape_entry_t    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/tape_ram_arbiter.sv
// Shares single-port main RAM between CPU accesses and buffered loader writes.
// Optional macro TAPE_RANGE_GUARD_EN drops loader writes outside [GUARD_LO, GUARD_HI].
//
// state     | meaning
// IDLE      | evaluate grant
// CPU_ISSUE | RAM samples the CPU command
// CPU_DONE  | capture ram_q, pulse ack
// TAPE_WR   | RAM samples the tape write
module tape_ram_arbiter
  import tape_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
`ifdef TAPE_RANGE_GUARD_EN
  ,
  parameter logic [15:0] GUARD_LO = 16'h0400,
  parameter logic [15:0] GUARD_HI = 16'hBFFF
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  tape_ram_arbiter_if.slave  bus
`ifdef TAPE_RANGE_GUARD_EN
  ,
  output logic               tape_range_err
`endif
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  arb_state_t   state_q, state_d;
  logic         tape_grant, cpu_grant;
  logic [SW-1:0] starve_q;
  logic         fifo_full, fifo_empty;
  logic         push_ok;
  tape_entry_t  head, push_entry;
  logic [15:0]  ram_addr_q;
  logic         ram_we_q;
  logic [7:0]   ram_din_q;
  logic [7:0]   cpu_dout_q;
  logic         cpu_ack_q;
  logic         is_write_q;
  logic         complete_q;
  logic         done_pending_q;
  logic         overflow_q;
  logic         drained;

`ifdef TAPE_RANGE_GUARD_EN
  logic in_range;
  logic range_err_q;
  assign in_range       = (bus.tape_addr >= GUARD_LO) && (bus.tape_addr <= GUARD_HI);
  assign push_ok        = bus.tape_wr && in_range;
  assign tape_range_err = range_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      range_err_q <= 1'b0;
    else if (bus.tape_wr && !in_range) range_err_q <= 1'b1;
  end
`else
  assign push_ok = bus.tape_wr;
`endif

  assign push_entry = '{addr: bus.tape_addr, data: bus.tape_dout};

  tape_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (tape_grant),
    .din     (push_entry),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tape_grant = 1'b0;
    cpu_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (starve_q >= SW'(MAX_WAIT))) begin
          tape_grant = 1'b1;
          state_d    = TAPE_WR;
        end else if (bus.cpu_req) begin
          cpu_grant = 1'b1;
          state_d   = CPU_ISSUE;
        end else if (!fifo_empty) begin
          tape_grant = 1'b1;
          state_d    = TAPE_WR;
        end
      end
      CPU_ISSUE: state_d = CPU_DONE;
      CPU_DONE:  state_d = IDLE;
      TAPE_WR:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Drained only once the last popped byte has left the TAPE_WR slot.
  assign drained = done_pending_q && fifo_empty && (state_q != TAPE_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ram_addr_q     <= '0;
      ram_we_q       <= 1'b0;
      ram_din_q      <= '0;
      cpu_dout_q     <= '0;
      cpu_ack_q      <= 1'b0;
      is_write_q     <= 1'b0;
      starve_q       <= '0;
      complete_q     <= 1'b0;
      done_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_ack_q <= 1'b0;
      if (tape_grant) begin
        ram_addr_q <= head.addr;
        ram_din_q  <= head.data;
        ram_we_q   <= 1'b1;
      end else if (cpu_grant) begin
        ram_addr_q <= bus.cpu_addr;
        ram_din_q  <= bus.cpu_din;
        ram_we_q   <= bus.cpu_we;
        is_write_q <= bus.cpu_we;
      end else begin
        ram_we_q <= 1'b0;
      end
      if (state_q == CPU_DONE) begin
        cpu_ack_q <= 1'b1;
        if (!is_write_q) cpu_dout_q <= bus.ram_q;
      end
      if (fifo_empty || tape_grant)
        starve_q <= '0;
      else if ((state_q != TAPE_WR) && (starve_q < SW'(MAX_WAIT)))
        starve_q <= starve_q + 1'b1;
      complete_q <= bus.tape_complete;
      if (drained) done_pending_q <= 1'b0;
      if (bus.tape_complete && !complete_q) done_pending_q <= 1'b1;
      if (push_ok && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_din       = ram_din_q;
  assign bus.cpu_dout      = cpu_dout_q;
  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.tape_ready    = !fifo_full;
  assign bus.tape_drained  = drained;
  assign bus.tape_overflow = overflow_q;

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Scoreboard bench for tape_ram_arbiter: stimulus queues expected RAM writes,
// CPU acks and drained pulses; a negedge monitor pops and compares them.
module tb_tape_ram_arbiter;
  import tape_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tape_ram_arbiter_if bus();
`ifdef TAPE_RANGE_GUARD_EN
  logic tape_range_err;
`endif

  tape_ram_arbiter #(.FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef TAPE_RANGE_GUARD_EN
    ,
    .tape_range_err (tape_range_err)
`endif
  );

  // RAM model: write on edge, read data registered one cycle after the command
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_q <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          at;
  } wr_exp_t;
  typedef struct {
    logic [7:0] data;
    int         at;
  } ack_exp_t;

  wr_exp_t  wr_q[$];
  ack_exp_t ack_q[$];
  int       drain_q[$];
  wr_exp_t  we_e;
  ack_exp_t ae_e;
  int       de_e;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ram_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ram_write: addr %h data %h, no write expected", bus.ram_addr, bus.ram_din);
        end else begin
          we_e = wr_q.pop_front();
          check("ram_wr_addr", bus.ram_addr, we_e.addr);
          check("ram_wr_data", bus.ram_din, we_e.data);
          if (we_e.at >= 0) check("ram_wr_cycle", cyc, we_e.at);
        end
      end
      if (bus.cpu_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cpu_ack: dout %h, no ack expected", bus.cpu_dout);
        end else begin
          ae_e = ack_q.pop_front();
          check("cpu_dout", bus.cpu_dout, ae_e.data);
          if (ae_e.at >= 0) check("cpu_ack_cycle", cyc, ae_e.at);
        end
      end
      if (bus.tape_drained === 1'b1) begin
        if (drain_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_drained: pulse at cycle %0d, none expected", cyc);
        end else begin
          de_e = drain_q.pop_front();
          check("drained_cycle", cyc, de_e);
        end
      end
    end
  end

  task automatic wait_quiet(input int budget);
    int t = 0;
    while ((wr_q.size() + ack_q.size() + drain_q.size()) != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("pending_events", wr_q.size() + ack_q.size() + drain_q.size(), 0);
    wr_q.delete();
    ack_q.delete();
    drain_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] exp_q, input bit chk_e0);
    int g = cyc + 1;
    int t = 0;
    ack_q.push_back(ack_exp_t'{data: exp_q, at: g + 2});
    if (we) wr_q.push_back(wr_exp_t'{addr: a, data: d, at: g});
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
    @(posedge clk);
    #1;
    if (chk_e0) begin
      check("e0_ram_addr", bus.ram_addr, a);
      check("e0_ram_we", bus.ram_we, we);
    end
    do begin
      @(negedge clk);
      t++;
    end while (bus.cpu_ack !== 1'b1 && t < 20);
    bus.cpu_req = 1'b0;
    if (bus.cpu_ack !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cpu_access_timeout: no ack within %0d cycles", t);
    end
  endtask

  task automatic cpu_stream(input logic [15:0] a, input int n_acc, input int budget);
    int acks = 0;
    int t = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_din = 8'h00;
    while (acks < n_acc && t < budget) begin
      @(negedge clk);
      t++;
      if (bus.cpu_ack === 1'b1) acks++;
    end
    bus.cpu_req = 1'b0;
    check("cpu_stream_acks", acks, n_acc);
  endtask

  task automatic tape_burst(input logic [15:0] a0, input logic [7:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      bus.tape_wr = 1'b1;
      bus.tape_addr = a0 + 16'(i);
      bus.tape_dout = d0 + 8'(i);
      @(negedge clk);
      check("tape_ready_burst", bus.tape_ready, 1'b1);
    end
    bus.tape_wr = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("rst_cpu_dout", bus.cpu_dout, 8'h00);
    check("rst_ram_addr", bus.ram_addr, 16'h0000);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_din", bus.ram_din, 8'h00);
    check("rst_drained", bus.tape_drained, 1'b0);
    check("rst_overflow", bus.tape_overflow, 1'b0);
    check("rst_tape_ready", bus.tape_ready, 1'b1);
  endtask

  initial begin
    int c0;
    int p;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0501] = 8'h10;
    mem[16'h0600] = 8'h5A;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.tape_wr = 1'b0; bus.tape_addr = '0; bus.tape_dout = '0; bus.tape_complete = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU read with exact latency, then write and read-back
    cpu_access(1'b0, 16'h0501, 8'h00, 8'h10, 1'b1);
    repeat (2) @(negedge clk);
    cpu_access(1'b1, 16'h0700, 8'hA5, 8'h10, 1'b1);
    repeat (2) @(negedge clk);
    cpu_access(1'b0, 16'h0700, 8'h00, 8'hA5, 1'b0);
    wait_quiet(20);

    // Back-to-back loader burst, CPU idle: one write every 2 cycles
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      wr_q.push_back(wr_exp_t'{addr: 16'h0500 + 16'(i), data: 8'h16 + 8'(i), at: c0 + 2 + 2*i});
    tape_burst(16'h0500, 8'h16, 4);
    wait_quiet(30);

    // Starvation guard: one queued byte against a continuous CPU requester
    p = cyc + 1;
    wr_q.push_back(wr_exp_t'{addr: 16'h0510, data: 8'h33, at: p + 9});
    ack_q.push_back(ack_exp_t'{data: 8'h5A, at: p + 2});
    ack_q.push_back(ack_exp_t'{data: 8'h5A, at: p + 5});
    ack_q.push_back(ack_exp_t'{data: 8'h5A, at: p + 8});
    ack_q.push_back(ack_exp_t'{data: 8'h5A, at: p + 13});
    fork
      cpu_stream(16'h0600, 4, 40);
      tape_burst(16'h0510, 8'h33, 1);
    join
    wait_quiet(30);

    // Completion coinciding with the last of 3 bytes; single drained pulse
    c0 = cyc;
    for (int i = 0; i < 3; i++)
      wr_q.push_back(wr_exp_t'{addr: 16'h0520 + 16'(i), data: 8'h40 + 8'(i), at: c0 + 2 + 2*i});
    drain_q.push_back(c0 + 7);
    for (int i = 0; i < 3; i++) begin
      bus.tape_wr = 1'b1;
      bus.tape_addr = 16'h0520 + 16'(i);
      bus.tape_dout = 8'h40 + 8'(i);
      if (i == 2) bus.tape_complete = 1'b1;
      @(negedge clk);
    end
    bus.tape_wr = 1'b0;
    wait_quiet(30);
    repeat (10) @(negedge clk);
    bus.tape_complete = 1'b0;
    repeat (2) @(negedge clk);

    // Overflow: CPU holds the RAM while 5 bytes arrive; the 5th is dropped
    for (int i = 0; i < 6; i++) ack_q.push_back(ack_exp_t'{data: 8'h5A, at: -1});
    for (int i = 0; i < 4; i++)
      wr_q.push_back(wr_exp_t'{addr: 16'h0530 + 16'(i), data: 8'h50 + 8'(i), at: -1});
    fork
      cpu_stream(16'h0600, 6, 60);
      begin
        for (int i = 0; i < 5; i++) begin
          bus.tape_wr = 1'b1;
          bus.tape_addr = 16'h0530 + 16'(i);
          bus.tape_dout = 8'h50 + 8'(i);
          @(negedge clk);
          if (i == 3) begin
            check("full_tape_ready", bus.tape_ready, 1'b0);
            check("overflow_before", bus.tape_overflow, 1'b0);
          end
          if (i == 4) check("overflow_set", bus.tape_overflow, 1'b1);
        end
        bus.tape_wr = 1'b0;
      end
    join
    wait_quiet(60);
    check("overflow_sticky", bus.tape_overflow, 1'b1);
    check("ready_after_drain", bus.tape_ready, 1'b1);

    // Reset in CPU_ISSUE with 2 bytes queued: no ack, no writes afterwards
    bus.tape_wr = 1'b1; bus.tape_addr = 16'h0540; bus.tape_dout = 8'h60;
    @(negedge clk);
    bus.tape_addr = 16'h0541; bus.tape_dout = 8'h61;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0600;
    @(negedge clk);
    bus.tape_wr = 1'b0;
    check("issue_ram_addr", bus.ram_addr, 16'h0600);
    reset_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_ready", bus.tape_ready, 1'b1);
    check("post_reset_overflow", bus.tape_overflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
